// File: rtl/eve_pkg.sv
// Shared EvE definitions: gene layout, Config fields, LFSR taps and the
// crossover FSM state type.
package eve_pkg;

  localparam int HDR_MSB   = 63;
  localparam int HDR_LSB   = 32;
  localparam int WEIGHT_W  = 8;
  localparam int N_WEIGHTS = 4;

  localparam int CFG_BIAS_LSB  = 0;
  localparam int CFG_BIAS_W    = 8;
  localparam int CFG_RSVD_LSB  = 8;
  localparam int CFG_RSVD_W    = 8;
  localparam int CFG_BROOD_LSB = 16;
  localparam int CFG_BROOD_W   = 16;

  localparam int              LFSR_W      = 36;
  localparam int              LFSR_TAP_HI = 35;
  localparam int              LFSR_TAP_LO = 24;
  localparam logic [LFSR_W-1:0] LFSR_RESET = 36'h1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BREED = 1'b1
  } xo_state_e;

endpackage

// File: rtl/eve_lfsr36.sv
// 36-bit Fibonacci LFSR (x^36 + x^25 + 1) with step enable and seed load.
// A zero seed would lock the register, so it is replaced by the reset value.
module eve_lfsr36
  import eve_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? LFSR_RESET : seed_i;
    end else if (step_i) begin
      state_d = {state_q[LFSR_W-2:0], state_q[LFSR_TAP_HI] ^ state_q[LFSR_TAP_LO]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LFSR_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/mux_2to1_8bit.sv
// Byte-wide two-input multiplexer: sel_i=1 picks b_i.
module mux_2to1_8bit (
  input  logic       sel_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/eve_crossover_engine.sv
// EvE crossover stage: takes a parent pair, emits a brood of per-byte
// crossover children, each tagged with the LFSR word used to build it.
module eve_crossover_engine
  import eve_pkg::*;
#(
  parameter int GENE_W = 64,
  parameter int RAND_W = 36
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [GENE_W-1:0] ParentA,
  input  logic [GENE_W-1:0] ParentB,
  input  logic [15:0]       FitA,
  input  logic [15:0]       FitB,
  input  logic [31:0]       Config,
  input  logic              InValid,
  output logic              InReady,
  input  logic              SeedLoad,
  input  logic [RAND_W-1:0] Seed,
  output logic [GENE_W-1:0] Crossover,
  output logic [RAND_W-1:0] Rand,
  output logic              LastChild,
  output logic              OutValid,
  input  logic              OutReady
);

  xo_state_e               state_q, state_d;
  logic [GENE_W-1:0]       fit_q, fit_d;
  logic [GENE_W-1:0]       oth_q, oth_d;
  logic [CFG_BIAS_W-1:0]   bias_q, bias_d;
  logic [CFG_BROOD_W-1:0]  last_idx_q, last_idx_d;
  logic [CFG_BROOD_W-1:0]  cnt_q, cnt_d;
  logic [GENE_W-1:0]       crossover_q, crossover_d;
  logic [RAND_W-1:0]       rand_q, rand_d;
  logic                    last_q, last_d;
  logic                    out_valid_q, out_valid_d;

  logic [RAND_W-1:0]       lfsr_state;
  logic                    gen;
  logic                    seed_load;
  logic [CFG_BIAS_W-1:0]   cfg_bias;
  logic [CFG_BROOD_W-1:0]  cfg_brood;
  logic [N_WEIGHTS-1:0]    byte_sel;
  logic [N_WEIGHTS*WEIGHT_W-1:0] child_weights;
  logic [GENE_W-1:0]       child_gene;
  logic                    unused_cfg_rsvd;

  assign cfg_bias        = Config[CFG_BIAS_LSB +: CFG_BIAS_W];
  assign cfg_brood       = Config[CFG_BROOD_LSB +: CFG_BROOD_W];
  assign unused_cfg_rsvd = ^Config[CFG_RSVD_LSB +: CFG_RSVD_W];

  assign InReady   = (state_q == ST_IDLE);
  assign gen       = (state_q == ST_BREED) && (!out_valid_q || OutReady);
  // A reseed racing an acceptance would perturb the brood being started.
  assign seed_load = (state_q == ST_IDLE) && SeedLoad && !InValid;

  eve_lfsr36 u_lfsr (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .step_i  (gen),
    .load_i  (seed_load),
    .seed_i  (Seed),
    .state_o (lfsr_state)
  );

  for (genvar gi = 0; gi < N_WEIGHTS; gi++) begin : g_weight
    assign byte_sel[gi] = (lfsr_state[gi*WEIGHT_W +: WEIGHT_W] < bias_q);

    mux_2to1_8bit u_mux (
      .sel_i (byte_sel[gi]),
      .a_i   (oth_q[gi*WEIGHT_W +: WEIGHT_W]),
      .b_i   (fit_q[gi*WEIGHT_W +: WEIGHT_W]),
      .y_o   (child_weights[gi*WEIGHT_W +: WEIGHT_W])
    );
  end

  assign child_gene = {fit_q[HDR_MSB:HDR_LSB], child_weights};

  always_comb begin
    state_d     = state_q;
    fit_d       = fit_q;
    oth_d       = oth_q;
    bias_d      = bias_q;
    last_idx_d  = last_idx_q;
    cnt_d       = cnt_q;
    crossover_d = crossover_q;
    rand_d      = rand_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;

    if (OutReady) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (InValid) begin
          // Fitness is resolved once here so the datapath only sees F and O.
          if (FitA >= FitB) begin
            fit_d = ParentA;
            oth_d = ParentB;
          end else begin
            fit_d = ParentB;
            oth_d = ParentA;
          end
          bias_d     = cfg_bias;
          last_idx_d = (cfg_brood == '0) ? '0 : cfg_brood - 16'd1;
          cnt_d      = '0;
          state_d    = ST_BREED;
        end
      end
      ST_BREED: begin
        if (gen) begin
          crossover_d = child_gene;
          rand_d      = lfsr_state;
          last_d      = (cnt_q == last_idx_q);
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 16'd1;
          if (cnt_q == last_idx_q) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      fit_q       <= '0;
      oth_q       <= '0;
      bias_q      <= '0;
      last_idx_q  <= '0;
      cnt_q       <= '0;
      crossover_q <= '0;
      rand_q      <= '0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fit_q       <= fit_d;
      oth_q       <= oth_d;
      bias_q      <= bias_d;
      last_idx_q  <= last_idx_d;
      cnt_q       <= cnt_d;
      crossover_q <= crossover_d;
      rand_q      <= rand_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Crossover = crossover_q;
  assign Rand      = rand_q;
  assign LastChild = last_q;
  assign OutValid  = out_valid_q;

endmodule

// File: tb/tb_eve_crossover_engine.sv
// Directed bench for eve_crossover_engine: expected children are queued when a
// pair is driven and checked by a monitor as the DUT hands them over.
module tb_eve_crossover_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [63:0] ParentA = '0;
  logic [63:0] ParentB = '0;
  logic [15:0] FitA = '0;
  logic [15:0] FitB = '0;
  logic [31:0] Config = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic        SeedLoad = 1'b0;
  logic [35:0] Seed = '0;
  logic [63:0] Crossover;
  logic [35:0] Rand;
  logic        LastChild;
  logic        OutValid;
  logic        OutReady = 1'b0;

  eve_crossover_engine dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ParentA   (ParentA),
    .ParentB   (ParentB),
    .FitA      (FitA),
    .FitB      (FitB),
    .Config    (Config),
    .InValid   (InValid),
    .InReady   (InReady),
    .SeedLoad  (SeedLoad),
    .Seed      (Seed),
    .Crossover (Crossover),
    .Rand      (Rand),
    .LastChild (LastChild),
    .OutValid  (OutValid),
    .OutReady  (OutReady)
  );

  always #5 Clk = ~Clk;

  logic [100:0] sb[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           n_taken    = 0;
  logic [35:0]  model_s    = 36'h1;

  task automatic chk(input string tag, input logic [100:0] obs, input logic [100:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] lfsr_next(input logic [35:0] s);
    return {s[34:0], s[35] ^ s[24]};
  endfunction

  function automatic logic [63:0] make_child(input logic [63:0] f, input logic [63:0] o,
                                             input logic [35:0] s, input logic [7:0] bias);
    logic [63:0] c;
    c[63:32] = f[63:32];
    for (int i = 0; i < 4; i++) begin
      c[8*i +: 8] = (s[8*i +: 8] < bias) ? f[8*i +: 8] : o[8*i +: 8];
    end
    return c;
  endfunction

  // Monitor: a handshake pops the head; a stalled child must already equal the head.
  always @(negedge Clk) begin
    if (Reset_n && OutValid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 101'(OutValid), 101'(0));
      end else if (OutReady) begin
        chk("child", {Crossover, Rand, LastChild}, sb.pop_front());
        n_taken++;
        $display("child %0d: crossover=%h rand=%h last=%b", n_taken, Crossover, Rand, LastChild);
      end else begin
        chk("stall_hold", {Crossover, Rand, LastChild}, sb[0]);
      end
    end
  end

  task automatic push_brood(input logic [63:0] a, input logic [63:0] b, input logic [15:0] fa,
                            input logic [15:0] fb, input logic [7:0] bias, input logic [15:0] brood);
    logic [63:0] f, o;
    int k;
    f = (fa >= fb) ? a : b;
    o = (fa >= fb) ? b : a;
    k = (brood == 0) ? 1 : int'(brood);
    for (int j = 0; j < k; j++) begin
      sb.push_back({make_child(f, o, model_s, bias), model_s, (j == k - 1)});
      model_s = lfsr_next(model_s);
    end
  endtask

  task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [15:0] fa,
                        input logic [15:0] fb, input logic [7:0] bias, input logic [15:0] brood,
                        input logic coinc_seed);
    push_brood(a, b, fa, fb, bias, brood);
    @(posedge Clk); #1;
    chk("in_ready_idle_pre", 101'(InReady), 101'(1));
    ParentA  = a;
    ParentB  = b;
    FitA     = fa;
    FitB     = fb;
    Config   = {brood, 8'h00, bias};
    InValid  = 1'b1;
    SeedLoad = coinc_seed;
    Seed     = 36'h5_5555_5555;
    @(posedge Clk); #1;
    InValid  = 1'b0;
    SeedLoad = 1'b0;
    chk("in_ready_breed", 101'(InReady), 101'(0));
  endtask

  task automatic drain(input logic [7:0] rdy_pat, input int n_pat, input logic seed_in_breed);
    int k;
    // Latched configuration must ignore this.
    Config = 32'h0003_A55A;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      OutReady = (k < n_pat) ? rdy_pat[k] : 1'b1;
      SeedLoad = seed_in_breed && (k == 1);
      Seed     = 36'h9_ABCD_1234;
      @(posedge Clk); #1;
      k++;
    end
    SeedLoad = 1'b0;
    OutReady = 1'b1;
    chk("drain_timeout", 101'(sb.size()), 101'(0));
    chk("in_ready_after", 101'(InReady), 101'(1));
    chk("out_valid_drop", 101'(OutValid), 101'(0));
  endtask

  task automatic seed_idle(input logic [35:0] s);
    @(posedge Clk); #1;
    SeedLoad = 1'b1;
    Seed     = s;
    @(posedge Clk); #1;
    SeedLoad = 1'b0;
    model_s  = (s == 0) ? 36'h1 : s;
  endtask

  initial begin
    int base;
    // Reset state
    #2 Reset_n = 1'b0;
    #2;
    chk("rst_out_valid", 101'(OutValid), 101'(0));
    chk("rst_last", 101'(LastChild), 101'(0));
    chk("rst_crossover", 101'(Crossover), 101'(0));
    chk("rst_rand", 101'(Rand), 101'(0));
    chk("rst_in_ready", 101'(InReady), 101'(1));
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    OutReady = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    chk("idle_out_valid", 101'(OutValid), 101'(0));

    // Tie selects A; then B fitter
    accept(64'hAAAA_AAAA_1111_1111, 64'hBBBB_BBBB_2222_2222, 16'd5, 16'd5, 8'd255, 16'd1, 1'b0);
    drain(8'h01, 1, 1'b0);
    accept(64'hAAAA_AAAA_1111_1111, 64'hBBBB_BBBB_2222_2222, 16'd5, 16'd6, 8'd255, 16'd1, 1'b0);
    drain(8'h01, 1, 1'b0);

    // Bias extremes
    accept(64'h1234_5678_0102_0304, 64'h8765_4321_F1F2_F3F4, 16'd9, 16'd3, 8'd0, 16'd3, 1'b0);
    drain(8'h01, 1, 1'b0);
    seed_idle(36'h0_0000_00FF);
    accept(64'hCAFE_F00D_1122_3344, 64'hDEAD_BEEF_5566_7788, 16'd100, 16'd1, 8'd255, 16'd1, 1'b0);
    drain(8'h01, 1, 1'b0);

    // Zero seed, brood of 4 under backpressure, ignored seed in BREED
    seed_idle(36'h0);
    accept(64'h0F0F_0F0F_A0B0_C0D0, 64'hF0F0_F0F0_0A0B_0C0D, 16'd7, 16'd2, 8'h80, 16'd4, 1'b0);
    drain(8'b0011_1001, 6, 1'b1);

    // BroodSize 0 gives one child; seed coincident with acceptance is ignored
    accept(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 16'd1, 16'd2, 8'h40, 16'd0, 1'b1);
    drain(8'h01, 1, 1'b0);

    // Reset mid-brood
    accept(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 16'd3, 16'd3, 8'h90, 16'd8, 1'b0);
    base = n_taken;
    OutReady = 1'b1;
    for (int k = 0; k < 100 && n_taken < base + 3; k++) begin
      @(posedge Clk); #1;
    end
    chk("midbrood_progress", 101'(n_taken - base >= 3), 101'(1));
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 101'(OutValid), 101'(0));
    chk("mid_rst_crossover", 101'(Crossover), 101'(0));
    chk("mid_rst_rand", 101'(Rand), 101'(0));
    chk("mid_rst_last", 101'(LastChild), 101'(0));
    chk("mid_rst_in_ready", 101'(InReady), 101'(1));
    sb.delete();
    model_s = 36'h1;
    #20 Reset_n = 1'b1;
    accept(64'h7777_8888_9999_AAAA, 64'h1212_3434_5656_7878, 16'd0, 16'd9, 8'hFF, 16'd1, 1'b0);
    drain(8'h01, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
